// File: rtl/bcd_mmss_counter_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg : shared state encoding and BCD digit limits for the mm:ss counter
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter : one wrapping BCD digit (0..MAX) with enable-qualified carry
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign carry = en & (q == MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_mmss_counter.sv
// -----------------------------------------------------------------------------
// bcd_mmss_counter : mm:ss BCD stopwatch with 1 Hz prescaler and button conditioning
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bcd_mmss_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       run,
  output logic       tick,
  output logic       rollover
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [1:0]      ss_sync;
  logic [1:0]      clr_sync;
  logic            ss_prev;
  logic            clr_prev;
  logic            ss_req;
  logic            clr_req;
  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   presc;
  logic            advance;
  logic            wrap;
  logic [3:0][3:0] digit_q;
  logic [4:0]      en_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync  <= 2'b00;
      clr_sync <= 2'b00;
      ss_prev  <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[0], start_stop};
      clr_sync <= {clr_sync[0], clear};
      ss_prev  <= ss_sync[1];
      clr_prev <= clr_sync[1];
    end
  end

  assign ss_req  = ss_sync[1] & ~ss_prev;
  assign clr_req = clr_sync[1] & ~clr_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOPPED;
    end else begin
      state <= state_next;
    end
  end

  // Clear outranks a simultaneous start/stop toggle.
  always_comb begin
    state_next = state;
    if (clr_req) begin
      state_next = ST_STOPPED;
    end else if (ss_req) begin
      state_next = (state == ST_RUNNING) ? ST_STOPPED : ST_RUNNING;
    end
  end

  // A request on the wrap edge suppresses the tick; the prescaler holds instead.
  assign advance = (state == ST_RUNNING) & ~ss_req & ~clr_req;
  assign wrap    = advance & (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr_req) begin
      presc <= '0;
    end else if (advance) begin
      presc <= wrap ? '0 : presc + 1'b1;
    end
  end

  assign en_chain[0] = wrap;

  // Digit 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens.
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_counter #(
      .MAX ((i % 2 == 0) ? BCD_MAX_ONES : BCD_MAX_TENS)
    ) u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_req),
      .en    (en_chain[i]),
      .q     (digit_q[i]),
      .carry (en_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else begin
      tick     <= wrap;
      rollover <= en_chain[4];
    end
  end

  assign run      = (state == ST_RUNNING);
  assign sec_ones = digit_q[0];
  assign sec_tens = digit_q[1];
  assign min_ones = digit_q[2];
  assign min_tens = digit_q[3];

endmodule

`default_nettype wire

// File: tb/tb_bcd_mmss_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_mmss_counter : directed + random stimulus against an elapsed-seconds model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_mmss_counter;

  localparam int TICK_DIV = 4;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear      = 1'b0;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
  logic        run, tick, rollover;
  logic [15:0] digits;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  bcd_mmss_counter #(.TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .run        (run),
    .tick       (tick),
    .rollover   (rollover)
  );

  assign digits = {min_tens, min_ones, sec_tens, sec_ones};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: elapsed seconds as an integer, requests seen two edges after sampling.
  int       m_secs  = 0;
  int       m_phase = 0;
  bit       m_run   = 1'b0;
  bit       m_tick  = 1'b0;
  bit       m_roll  = 1'b0;
  bit [2:0] ss_hist  = 3'b000;
  bit [2:0] clr_hist = 3'b000;
  bit       m_ss_req, m_clr_req;

  assign m_ss_req  = ss_hist[1] & ~ss_hist[2];
  assign m_clr_req = clr_hist[1] & ~clr_hist[2];

  function automatic logic [15:0] bcd_of(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_secs <= 0; m_phase <= 0; m_run <= 1'b0; m_tick <= 1'b0; m_roll <= 1'b0;
      ss_hist <= 3'b000; clr_hist <= 3'b000;
    end else begin
      ss_hist  <= {ss_hist[1:0], start_stop};
      clr_hist <= {clr_hist[1:0], clear};
      m_tick   <= 1'b0;
      m_roll   <= 1'b0;
      if (m_clr_req) begin
        m_secs <= 0; m_phase <= 0; m_run <= 1'b0;
      end else if (m_ss_req) begin
        m_run <= !m_run;
      end else if (m_run) begin
        if (m_phase == TICK_DIV - 1) begin
          m_phase <= 0;
          m_secs  <= (m_secs + 1) % 3600;
          m_tick  <= 1'b1;
          m_roll  <= (m_secs == 3599);
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("model_digits", 32'(digits), 32'(bcd_of(m_secs)));
      check_val("model_run", 32'(run), 32'(m_run));
      check_val("model_tick", 32'(tick), 32'(m_tick));
      check_val("model_rollover", 32'(rollover), 32'(m_roll));
    end
  end

  task automatic pulse_ss();
    @(negedge clk) start_stop = 1'b1;
    @(negedge clk) start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    int          last, ticks, toggles;
    bit          prev_run, done;
    logic [15:0] prev_digits;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_digits", 32'(digits), 32'h0);
    check_val("rst_run", 32'(run), 32'h0);
    check_val("rst_tick", 32'(tick), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Start latency and tick cadence
    @(negedge clk) start_stop = 1'b1;
    @(posedge clk);
    @(negedge clk) start_stop = 1'b0;
    @(posedge clk); #1 check_val("lat_n1_run", 32'(run), 32'h0);
    @(posedge clk); #1 check_val("lat_n2_run", 32'(run), 32'h1);
    last  = cyc;
    ticks = 0;
    for (int i = 0; i < 100 && ticks < 10; i++) begin
      @(posedge clk); #1;
      if (tick) begin
        check_val("tick_period", 32'(cyc - last), 32'(TICK_DIV));
        last = cyc;
        ticks++;
      end
    end
    check_val("ten_ticks_count", 32'(ticks), 32'd10);
    check_val("ten_ticks_digits", 32'(digits), 32'h0010);

    // Stop at 00:07 with two prescaler cycles spent, idle, then resume
    pulse_clr();
    repeat (4) @(negedge clk);
    check_val("clear_digits", 32'(digits), 32'h0);
    check_val("clear_run", 32'(run), 32'h0);
    pulse_ss();
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (tick && digits == 16'h0007) done = 1'b1;
    end
    check_val("reach_0007", 32'(done), 32'h1);
    pulse_ss();
    repeat (100) @(negedge clk);
    check_val("pause_digits", 32'(digits), 32'h0007);
    check_val("pause_run", 32'(run), 32'h0);
    @(negedge clk) start_stop = 1'b1;
    @(posedge clk);
    @(negedge clk) start_stop = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 check_val("resume_run", 32'(run), 32'h1);
    check_val("resume_tick0", 32'(tick), 32'h0);
    @(posedge clk); #1 check_val("resume_tick1", 32'(tick), 32'h0);
    @(posedge clk); #1 check_val("resume_tick2", 32'(tick), 32'h1);
    check_val("resume_digits", 32'(digits), 32'h0008);

    // Asynchronous reset between clock edges while running
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_val("arst_digits", 32'(digits), 32'h0);
    check_val("arst_run", 32'(run), 32'h0);
    check_val("arst_tick", 32'(tick), 32'h0);
    check_val("arst_rollover", 32'(rollover), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clear and start_stop rising together while running
    pulse_ss();
    repeat ($urandom_range(10, 30)) @(negedge clk);
    @(negedge clk) begin start_stop = 1'b1; clear = 1'b1; end
    @(posedge clk);
    @(negedge clk) begin start_stop = 1'b0; clear = 1'b0; end
    @(posedge clk);
    @(posedge clk); #1;
    check_val("both_digits", 32'(digits), 32'h0);
    check_val("both_run", 32'(run), 32'h0);
    ticks = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tick) ticks++;
    end
    check_val("both_no_tick", 32'(ticks), 32'h0);

    // Held level toggles once; a single-cycle pulse still toggles
    @(negedge clk) start_stop = 1'b1;
    prev_run = run;
    toggles  = 0;
    repeat (55) begin
      @(negedge clk);
      if (run !== prev_run) toggles++;
      prev_run = run;
    end
    start_stop = 1'b0;
    repeat (5) @(negedge clk);
    check_val("hold_toggles", 32'(toggles), 32'd1);
    check_val("hold_run", 32'(run), 32'h1);
    pulse_ss();
    repeat (4) @(negedge clk);
    check_val("pulse_run", 32'(run), 32'h0);

    // Random button activity against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0)  start_stop = ~start_stop;
      if ($urandom_range(0, 199) == 0) clear      = ~clear;
    end
    start_stop = 1'b0;
    clear      = 1'b0;
    repeat (6) @(negedge clk);

    // Full hour: 59:59 wraps to 00:00 with a single-cycle rollover
    pulse_clr();
    repeat (4) @(negedge clk);
    pulse_ss();
    ticks       = 0;
    done        = 1'b0;
    prev_digits = digits;
    for (int i = 0; i < 16000 && !done; i++) begin
      @(posedge clk); #1;
      if (tick) ticks++;
      if (rollover) begin
        done = 1'b1;
        check_val("roll_prev_digits", 32'(prev_digits), 32'h5959);
        check_val("roll_digits", 32'(digits), 32'h0);
        check_val("roll_tick", 32'(tick), 32'h1);
        check_val("roll_tick_count", 32'(ticks), 32'd3600);
      end
      prev_digits = digits;
    end
    check_val("roll_seen", 32'(done), 32'h1);
    @(posedge clk); #1;
    check_val("roll_one_cycle", 32'(rollover), 32'h0);
    check_val("roll_tick_one_cycle", 32'(tick), 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
